// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM states,
// the queued command layout and the divide-by-zero predicate.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;
  localparam int CMD_W  = SEL_W + 2 * DATA_W;

  typedef enum logic [SEL_W-1:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_DIV = 4'b0011,
    OP_MOD = 4'b0100,
    OP_SHL = 4'b0101,
    OP_SHR = 4'b0110,
    OP_ROL = 4'b0111,
    OP_AND = 4'b1000,
    OP_OR  = 4'b1001,
    OP_XOR = 4'b1010,
    OP_NOT = 4'b1011,
    OP_NOR = 4'b1100,
    OP_LT  = 4'b1101,
    OP_GT  = 4'b1110,
    OP_EQ  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_cmd_t;

  function automatic logic is_div_by_zero(input logic [SEL_W-1:0]  sel,
                                          input logic [DATA_W-1:0] b);
    return (sel == OP_DIV) && (b == '0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue for the sequencer: DEPTH entries, head visible on rdata.
// Pointers carry one extra bit so full and empty can be told apart.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands, drives them one at a time into an external ALU,
// captures each result and hands it to the consumer with valid/ready.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_carry,
  output logic              res_err,
  output logic [15:0]       ops_done
);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_carry_q, res_carry_d;
  logic              res_err_q, res_err_d;
  logic [15:0]       ops_done_q, ops_done_d;

  alu_cmd_t cmd_in;
  alu_cmd_t fifo_head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_pop;

  assign cmd_in    = {cmd_sel, cmd_a, cmd_b};
  assign cmd_ready = !fifo_full;

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .pop   (fifo_pop),
    .wdata (cmd_in),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_err_d   = res_err_q;
    ops_done_d  = ops_done_q;
    fifo_pop    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Divide by zero overrides whatever the external ALU produced.
        if (is_div_by_zero(alu_sel_q, alu_b_q)) begin
          res_data_d  = 8'hFF;
          res_carry_d = 1'b0;
          res_err_d   = 1'b1;
        end else begin
          res_data_d  = alu_out;
          res_carry_d = (alu_sel_q == OP_ADD) && alu_carry;
          res_err_d   = 1'b0;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) begin
          ops_done_d = ops_done_q + 16'd1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_EXEC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fifo_pop) begin
      alu_a_d   = fifo_head.a;
      alu_b_d   = fifo_head.b;
      alu_sel_d = fifo_head.sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_err_q   <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_err_q   <= res_err_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_valid = (state_q == ST_DONE);
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign res_err   = res_err_q;
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU attached.
// Non-ADD opcodes drive alu_carry high so carry masking is exercised.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_sel;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_out;
  logic        alu_carry;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic        res_carry;
  logic        res_err;
  logic [15:0] ops_done;
  logic [8:0]  alu_sum;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sel   (cmd_sel),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_err   (res_err),
    .ops_done  (ops_done)
  );

  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};

  always_comb begin
    alu_out   = alu_a ^ alu_b;
    alu_carry = 1'b1;
    case (alu_sel)
      4'b0000: begin
        alu_out   = alu_sum[7:0];
        alu_carry = alu_sum[8];
      end
      4'b0001: alu_out = alu_a - alu_b;
      4'b0011: alu_out = (alu_b == 8'h00) ? 8'h5A : alu_a / alu_b;
      4'b1000: alu_out = alu_a & alu_b;
      default: alu_out = alu_a ^ alu_b;
    endcase
  end

  task automatic push_cmd(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_sel   = sel;
    cmd_a     = a;
    cmd_b     = b;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for res_valid, samples the result, then lets one edge pass
  // so a res_ready=1 handshake completes before returning.
  task automatic get_result(output logic ok, output logic [7:0] data,
                            output logic c, output logic e);
    ok = 1'b0; data = 8'h00; c = 1'b0; e = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (res_valid) begin
        ok = 1'b1; data = res_data; c = res_carry; e = res_err;
      end else begin
        @(negedge clk);
      end
    end
    if (ok) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_sel = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (res_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_res_valid: got %b expected 0", res_valid); end
    tests_run++;
    if (cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    tests_run++;
    if (ops_done !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_ops_done: got %h expected 0000", ops_done); end
    tests_run++;
    if ({alu_a, alu_b, alu_sel} !== 20'h00000) begin tests_failed++; $display("[TB] FAIL reset_alu_regs: got %h expected 00000", {alu_a, alu_b, alu_sel}); end
    tests_run++;
    if ({res_data, res_carry, res_err} !== 10'h000) begin tests_failed++; $display("[TB] FAIL reset_result: got %h expected 000", {res_data, res_carry, res_err}); end
  endtask

  task automatic test_add();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = 4'h0; cmd_a = 8'h0A; cmd_b = 8'h02; res_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    tests_run++;
    if (res_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL add_valid_e0: got %b expected 0", res_valid); end
    @(negedge clk);
    tests_run++;
    if (res_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL add_valid_e1: got %b expected 0", res_valid); end
    tests_run++;
    if ({alu_sel, alu_a, alu_b} !== 20'h00A02) begin tests_failed++; $display("[TB] FAIL add_pop: got %h expected 00A02", {alu_sel, alu_a, alu_b}); end
    @(negedge clk);
    tests_run++;
    if (res_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL add_valid_e2: got %b expected 1", res_valid); end
    tests_run++;
    if ({res_data, res_carry, res_err} !== {8'h0C, 1'b0, 1'b0}) begin tests_failed++; $display("[TB] FAIL add_result: got %h/%b/%b expected 0c/0/0", res_data, res_carry, res_err); end
    @(negedge clk);
    tests_run++;
    if (res_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL add_valid_after: got %b expected 0", res_valid); end
    tests_run++;
    if (ops_done !== 16'd1) begin tests_failed++; $display("[TB] FAIL add_ops_done: got %0d expected 1", ops_done); end
  endtask

  task automatic test_add_carry();
    logic ok; logic [7:0] d; logic c; logic e;
    push_cmd(4'h0, 8'hF6, 8'h0A);
    get_result(ok, d, c, e);
    tests_run++;
    if (!ok || d !== 8'h00 || c !== 1'b1 || e !== 1'b0) begin tests_failed++; $display("[TB] FAIL add_carry: got ok=%b %h/%b/%b expected 00/1/0", ok, d, c, e); end
    push_cmd(4'h8, 8'hF6, 8'h0A);
    get_result(ok, d, c, e);
    tests_run++;
    if (!ok || d !== 8'h02 || c !== 1'b0 || e !== 1'b0) begin tests_failed++; $display("[TB] FAIL and_no_carry: got ok=%b %h/%b/%b expected 02/0/0", ok, d, c, e); end
  endtask

  task automatic test_div_zero();
    logic ok; logic [7:0] d; logic c; logic e;
    push_cmd(4'h3, 8'h10, 8'h00);
    get_result(ok, d, c, e);
    tests_run++;
    if (!ok || d !== 8'hFF || c !== 1'b0 || e !== 1'b1) begin tests_failed++; $display("[TB] FAIL div_zero: got ok=%b %h/%b/%b expected ff/0/1", ok, d, c, e); end
    push_cmd(4'h3, 8'h10, 8'h04);
    get_result(ok, d, c, e);
    tests_run++;
    if (!ok || d !== 8'h04 || c !== 1'b0 || e !== 1'b0) begin tests_failed++; $display("[TB] FAIL div_normal: got ok=%b %h/%b/%b expected 04/0/0", ok, d, c, e); end
  endtask

  task automatic test_back_pressure();
    logic ok; logic [7:0] d; logic c; logic e;
    int accepted;
    int seen;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    res_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_sel = 4'h0; cmd_a = 8'(i + 1); cmd_b = 8'h10;
      if (cmd_ready) accepted++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    tests_run++;
    if (accepted != 5) begin tests_failed++; $display("[TB] FAIL bp_accepted: got %0d expected 5", accepted); end
    tests_run++;
    if (cmd_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_cmd_ready: got %b expected 0", cmd_ready); end
    repeat (2) @(negedge clk);
    tests_run++;
    if (res_valid !== 1'b1 || res_data !== 8'h11) begin tests_failed++; $display("[TB] FAIL bp_hold: got %b/%h expected 1/11", res_valid, res_data); end
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_result(ok, d, c, e);
      tests_run++;
      if (!ok || d !== 8'(8'h11 + i)) begin tests_failed++; $display("[TB] FAIL bp_order_%0d: got ok=%b %h expected %h", i, ok, d, 8'(8'h11 + i)); end
    end
    tests_run++;
    if (ops_done !== 16'd5) begin tests_failed++; $display("[TB] FAIL bp_ops_done: got %0d expected 5", ops_done); end
    seen = 0;
    repeat (6) begin
      if (res_valid) seen++;
      @(negedge clk);
    end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("[TB] FAIL bp_extra_result: got %0d cycles valid expected 0", seen); end
  endtask

  task automatic test_reset_mid_op();
    logic ok; logic [7:0] d; logic c; logic e;
    int seen;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_sel = 4'h0; cmd_a = 8'(8'h40 + i); cmd_b = 8'h01;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    tests_run++;
    if (res_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_mid_pre_done: got %b expected 1", res_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (res_valid !== 1'b0 || ops_done !== 16'd0 || cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_mid_state: got valid=%b ops=%0d ready=%b expected 0/0/1", res_valid, ops_done, cmd_ready); end
    res_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      if (res_valid) seen++;
      @(negedge clk);
    end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("[TB] FAIL rst_mid_leak: got %0d cycles valid expected 0", seen); end
    push_cmd(4'h1, 8'h20, 8'h05);
    get_result(ok, d, c, e);
    tests_run++;
    if (!ok || d !== 8'h1B || c !== 1'b0 || e !== 1'b0 || ops_done !== 16'd1) begin tests_failed++; $display("[TB] FAIL rst_mid_resume: got ok=%b %h/%b/%b ops=%0d expected 1b/0/0 ops=1", ok, d, c, e, ops_done); end
  endtask

  task automatic test_ops_wrap();
    logic ok; logic [7:0] d; logic c; logic e;
    logic [15:0] expected_ops [3];
    expected_ops[0] = 16'hFFFF;
    expected_ops[1] = 16'h0000;
    expected_ops[2] = 16'h0001;
    @(negedge clk);
    force dut.ops_done_q = 16'hFFFE;
    @(negedge clk);
    release dut.ops_done_q;
    for (int i = 0; i < 3; i++) begin
      push_cmd(4'h0, 8'h01, 8'h01);
      get_result(ok, d, c, e);
      tests_run++;
      if (!ok || d !== 8'h02 || ops_done !== expected_ops[i]) begin tests_failed++; $display("[TB] FAIL wrap_%0d: got ok=%b data=%h ops=%h expected 02 ops=%h", i, ok, d, ops_done, expected_ops[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_carry();
    test_div_zero();
    test_back_pressure();
    test_reset_mid_op();
    test_ops_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
